rob_commit_ctrl: RTL and testbench
==================================

Name: rob_commit_ctrl

Overview:
Reorder-buffer controller that sequences the architectural register file.
- Allocates RoB ids at issue and drives the register file's rename write (issue_rob_id/issue_rd).
- Collects CDB write-backs and answers operand-ready queries.
- Retires entries in order through the register file's commit port.
- Flushes everything on a mispredicted branch reaching the head.
- Sits between decoder/dispatch, the CDB and the register file.

Parameters:
ROB_SIZE_WIDTH, 4, id width. Id 0 means "none". Valid ids are 1..DEPTH, where DEPTH = 2^ROB_SIZE_WIDTH - 1.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rdy  in  1  global enable; all state holds when low
issue_valid  in  1  dispatch presents an instruction
issue_rd_in  in  5  destination register (0 = no architectural write)
issue_is_branch  in  1  instruction is a conditional branch/jalr
issue_ready  out  1  entry free and no flush this cycle
issue_rob_id  out  W  id allocated this cycle, else 0 (register-file rename port)
issue_rd  out  5  rd of the allocated entry, else 0
wb_valid  in  1  CDB broadcast
wb_rob_id  in  W  producing entry
wb_value  in  32  result
wb_mispredict  in  1  branch resolved wrongly (meaningful only for branch entries)
wb_target  in  32  correct PC for a mispredict
ask_rob_id1, ask_rob_id2  in  W  operand query ids
get_value1, get_value2  out  32  entry value
get_ready1, get_ready2  out  1  entry result available
commit_rob_id  out  W  retiring id, else 0
commit_rd  out  5  retiring rd
commit_value  out  32  retiring value
flush  out  1  one-cycle pulse, registered
flush_pc  out  32  redirect PC, valid while flush=1

Behaviour:
- Storage: per entry valid, ready, is_branch, mispredict, rd[4:0], value[31:0], target[31:0].
- Pointers: head, tail and count. Pointers wrap DEPTH -> 1 and never take the value 0.
- Reset: all entries invalid; head = tail = 1; count = 0; flush = 0; flush_pc = 0. All combinational outputs read 0 while rst is high.
- rdy = 0:
  - No state changes.
  - issue_ready, issue_rob_id and commit_rob_id forced to 0.
  - Query outputs remain live.
- issue_ready = (count < DEPTH) and not flush and not head_flush_commit. It is computed from registered state only.
- Issue fires when issue_valid, issue_ready and rdy are all high:
  - Entry at tail is written: valid = 1, ready = 0, flags cleared.
  - tail advances.
  - issue_rob_id = tail and issue_rd = issue_rd_in in the same cycle (combinational), so the register file records the dependency at that edge.
  - If issue_rd_in = 0: the entry is still allocated, but issue_rob_id is driven 0 (no rename).
- Write-back when wb_valid and the addressed entry is valid:
  - Sets ready = 1, value, mispredict, target.
  - Write-back to an invalid entry is ignored.
- Query: get_readyN = 1 when entry askN is valid and ready, or when wb_valid and wb_rob_id == askN (same-cycle bypass; get_valueN then equals wb_value). askN = 0 gives ready 0, value 0.
- Commit: combinational, at most one per cycle. Fires when the head entry is valid and ready (registered state; no bypass from this cycle's wb).
  - commit_rob_id = head, commit_rd = rd, commit_value = value.
  - If rd = 0: commit_rob_id is driven 0, but the entry still retires.
  - head advances and the entry is invalidated at the edge.
- head_flush_commit = commit fires and the head entry is a branch with mispredict set. At that edge:
  - The branch's own commit outputs are still driven.
  - All entries are cleared; head = tail = 1; count = 0.
  - flush <= 1 and flush_pc <= target.
  - flush is high for exactly the following cycle; issue is blocked during it.
  - Any issue or write-back in the head_flush_commit cycle is discarded.
- Count update: +1 on issue, -1 on commit, unchanged when both happen.
- Full plus simultaneous commit: issue is still refused that cycle (no same-cycle reuse).
- Empty: no commit. An issue in that cycle cannot commit before the next cycle.
- Reset mid-operation overrides issue, write-back and flush.

Decomposition:
- Shared config package: ROB_SIZE_WIDTH, ROB_DEPTH, ROB_NONE = 0, and a pointer-increment-with-wrap function.
- One natural sub-module, rob_query_port, instantiated twice: lookup plus write-back bypass for a single ask id.

Test Plan:
1. Issue rd=5, then rd=6 -> issue_rob_id 1, 2. wb(2, 0x22) then wb(1, 0x11) -> commit id1 rd5 0x11 in the next cycle, then id2 rd6 0x22 in the cycle after; retirement stays in order.
2. Issue 15 entries with no wb -> issue_ready = 0 after the 15th. Commit the head and present issue the same cycle -> that issue is refused; the next cycle it gets id 1 (wrap).
3. ask_rob_id1 = 3 while wb(3, 0xABCD) is on the CDB -> get_ready1 = 1, get_value1 = 0xABCD in the same cycle. ask 0 -> ready 0.
4. Branch id1 with wb mispredict and target 0x1000; ids 2..4 pending -> id1 commits; next cycle flush = 1, flush_pc = 0x1000; count 0; the next issue gets id 1.
5. Issue rd=0 -> issue_rob_id = 0. After wb, commit_rob_id = 0, but the head advances.
6. Hold rdy = 0 for 3 cycles with wb pending -> no state change. rst mid-stream -> all outputs 0 and the next issue gets id 1.

Source files
------------

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared reorder-buffer configuration: id width, depth, entry layout and pointer wrap.
package rob_commit_ctrl_pkg;

  localparam int ROB_SIZE_WIDTH = 4;
  localparam int ROB_DEPTH      = (1 << ROB_SIZE_WIDTH) - 1;

  typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;

  // Id 0 is reserved for "none", so live ids run 1..ROB_DEPTH.
  localparam rob_id_t ROB_NONE  = '0;
  localparam rob_id_t ROB_FIRST = rob_id_t'(1);
  localparam rob_id_t ROB_LAST  = rob_id_t'(ROB_DEPTH);

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic        is_branch;
    logic        mispredict;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [31:0] target;
  } rob_entry_t;

  function automatic rob_id_t rob_ptr_inc(input rob_id_t p);
    return (p == ROB_LAST) ? ROB_FIRST : p + ROB_FIRST;
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Dispatch / CDB / register-file side signals of the reorder-buffer controller.
// Handshake: an issue is accepted in the cycle issue_valid && issue_ready are both high.
interface rob_commit_ctrl_if;
  import rob_commit_ctrl_pkg::*;

  logic        issue_valid;
  logic [4:0]  issue_rd_in;
  logic        issue_is_branch;
  logic        issue_ready;
  rob_id_t     issue_rob_id;
  logic [4:0]  issue_rd;
  logic        wb_valid;
  rob_id_t     wb_rob_id;
  logic [31:0] wb_value;
  logic        wb_mispredict;
  logic [31:0] wb_target;
  rob_id_t     ask_rob_id1;
  rob_id_t     ask_rob_id2;
  logic [31:0] get_value1;
  logic [31:0] get_value2;
  logic        get_ready1;
  logic        get_ready2;
  rob_id_t     commit_rob_id;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic        flush;
  logic [31:0] flush_pc;

  modport master (
    output issue_valid, issue_rd_in, issue_is_branch,
    output wb_valid, wb_rob_id, wb_value, wb_mispredict, wb_target,
    output ask_rob_id1, ask_rob_id2,
    input  issue_ready, issue_rob_id, issue_rd,
    input  get_value1, get_value2, get_ready1, get_ready2,
    input  commit_rob_id, commit_rd, commit_value, flush, flush_pc
  );

  modport slave (
    input  issue_valid, issue_rd_in, issue_is_branch,
    input  wb_valid, wb_rob_id, wb_value, wb_mispredict, wb_target,
    input  ask_rob_id1, ask_rob_id2,
    output issue_ready, issue_rob_id, issue_rd,
    output get_value1, get_value2, get_ready1, get_ready2,
    output commit_rob_id, commit_rd, commit_value, flush, flush_pc
  );

endinterface

// File: rtl/rob_commit_ctrl_query_port.sv
// Operand-ready lookup for one ask id, with same-cycle bypass from the CDB.
module rob_query_port
  import rob_commit_ctrl_pkg::*;
(
  input  logic        i_rst,
  input  rob_id_t     i_ask_id,
  input  logic        i_valid [0:ROB_DEPTH],
  input  logic        i_ready [0:ROB_DEPTH],
  input  logic [31:0] i_value [0:ROB_DEPTH],
  input  logic        i_wb_valid,
  input  rob_id_t     i_wb_rob_id,
  input  logic [31:0] i_wb_value,
  output logic        o_ready,
  output logic [31:0] o_value
);

  always_comb begin
    o_ready = 1'b0;
    o_value = '0;
    if (!i_rst && i_ask_id != ROB_NONE) begin
      if (i_wb_valid && i_wb_rob_id == i_ask_id) begin
        o_ready = 1'b1;
        o_value = i_wb_value;
      end else begin
        o_ready = i_valid[i_ask_id] && i_ready[i_ask_id];
        o_value = i_value[i_ask_id];
      end
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer controller: in-order allocate, CDB collect, in-order retire,
// and a full flush when a mispredicted branch retires.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  rob_commit_ctrl_if.slave  bus
);

  rob_entry_t  r_rob [0:ROB_DEPTH];
  rob_id_t     r_head;
  rob_id_t     r_tail;
  rob_id_t     r_count;
  logic        r_flush;
  logic [31:0] r_flush_pc;

  rob_entry_t  w_head_e;
  logic        w_commit;
  logic        w_head_flush;
  logic        w_issue_ready;
  logic        w_issue;
  logic        w_valid [0:ROB_DEPTH];
  logic        w_ready [0:ROB_DEPTH];
  logic [31:0] w_value [0:ROB_DEPTH];

  // Commit looks only at registered head state; a same-cycle write-back retires next cycle.
  assign w_head_e      = r_rob[r_head];
  assign w_commit      = !rst && rdy && w_head_e.valid && w_head_e.ready;
  assign w_head_flush  = w_commit && w_head_e.is_branch && w_head_e.mispredict;
  assign w_issue_ready = !rst && rdy && (r_count < ROB_LAST) && !r_flush && !w_head_flush;
  assign w_issue       = bus.issue_valid && w_issue_ready;

  assign bus.issue_ready   = w_issue_ready;
  assign bus.issue_rob_id  = (w_issue && bus.issue_rd_in != 5'd0) ? r_tail : ROB_NONE;
  assign bus.issue_rd      = w_issue ? bus.issue_rd_in : 5'd0;
  assign bus.commit_rob_id = (w_commit && w_head_e.rd != 5'd0) ? r_head : ROB_NONE;
  assign bus.commit_rd     = w_commit ? w_head_e.rd : 5'd0;
  assign bus.commit_value  = w_commit ? w_head_e.value : 32'd0;
  assign bus.flush         = r_flush && !rst;
  assign bus.flush_pc      = rst ? 32'd0 : r_flush_pc;

  always_comb begin
    for (int i = 0; i <= ROB_DEPTH; i++) begin
      w_valid[i] = r_rob[i].valid;
      w_ready[i] = r_rob[i].ready;
      w_value[i] = r_rob[i].value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= ROB_DEPTH; i++) r_rob[i] <= '0;
      r_head     <= ROB_FIRST;
      r_tail     <= ROB_FIRST;
      r_count    <= ROB_NONE;
      r_flush    <= 1'b0;
      r_flush_pc <= 32'd0;
    end else if (rdy) begin
      r_flush <= 1'b0;
      if (w_head_flush) begin
        // Issue and write-back in this cycle are dropped along with everything else.
        for (int i = 0; i <= ROB_DEPTH; i++) r_rob[i].valid <= 1'b0;
        r_head     <= ROB_FIRST;
        r_tail     <= ROB_FIRST;
        r_count    <= ROB_NONE;
        r_flush    <= 1'b1;
        r_flush_pc <= w_head_e.target;
      end else begin
        if (bus.wb_valid && r_rob[bus.wb_rob_id].valid) begin
          r_rob[bus.wb_rob_id].ready      <= 1'b1;
          r_rob[bus.wb_rob_id].value      <= bus.wb_value;
          r_rob[bus.wb_rob_id].mispredict <= bus.wb_mispredict;
          r_rob[bus.wb_rob_id].target     <= bus.wb_target;
        end
        if (w_issue) begin
          r_rob[r_tail] <= '{valid: 1'b1, ready: 1'b0, is_branch: bus.issue_is_branch,
                             mispredict: 1'b0, rd: bus.issue_rd_in, value: 32'd0, target: 32'd0};
          r_tail <= rob_ptr_inc(r_tail);
        end
        if (w_commit) begin
          r_rob[r_head].valid <= 1'b0;
          r_head <= rob_ptr_inc(r_head);
        end
        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + ROB_FIRST;
          2'b01:   r_count <= r_count - ROB_FIRST;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  rob_query_port u_query1 (
    .i_rst       (rst),
    .i_ask_id    (bus.ask_rob_id1),
    .i_valid     (w_valid),
    .i_ready     (w_ready),
    .i_value     (w_value),
    .i_wb_valid  (bus.wb_valid),
    .i_wb_rob_id (bus.wb_rob_id),
    .i_wb_value  (bus.wb_value),
    .o_ready     (bus.get_ready1),
    .o_value     (bus.get_value1)
  );

  rob_query_port u_query2 (
    .i_rst       (rst),
    .i_ask_id    (bus.ask_rob_id2),
    .i_valid     (w_valid),
    .i_ready     (w_ready),
    .i_value     (w_value),
    .i_wb_valid  (bus.wb_valid),
    .i_wb_rob_id (bus.wb_rob_id),
    .i_wb_value  (bus.wb_value),
    .o_ready     (bus.get_ready2),
    .o_value     (bus.get_value2)
  );

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: scoreboard of issued {id, rd} checked at retirement.
module tb_rob_commit_ctrl;
  import rob_commit_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  rob_commit_ctrl_if bus ();

  rob_commit_ctrl dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [8:0]  exp_q [$];
  logic [31:0] m_val [0:15];
  logic [3:0]  m_tail;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] nxt(input logic [3:0] id);
    return (id == 4'd15) ? 4'd1 : id + 4'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rdy                 = 1'b1;
    bus.issue_valid     = 1'b0;
    bus.issue_rd_in     = 5'd0;
    bus.issue_is_branch = 1'b0;
    bus.wb_valid        = 1'b0;
    bus.wb_rob_id       = '0;
    bus.wb_value        = 32'd0;
    bus.wb_mispredict   = 1'b0;
    bus.wb_target       = 32'd0;
    bus.ask_rob_id1     = '0;
    bus.ask_rob_id2     = '0;
  endtask

  task automatic cycle();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_tail = 4'd1;
  endtask

  task automatic do_reset();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic issue(input logic [4:0] rd, input logic br);
    bus.issue_valid     = 1'b1;
    bus.issue_rd_in     = rd;
    bus.issue_is_branch = br;
    #1;
    chk("issue_ready", 32'(bus.issue_ready), 32'd1);
    chk("issue_rob_id", 32'(bus.issue_rob_id), (rd == 5'd0) ? 32'd0 : 32'(m_tail));
    chk("issue_rd", 32'(bus.issue_rd), 32'(rd));
    exp_q.push_back({m_tail, rd});
    m_tail = nxt(m_tail);
  endtask

  task automatic wb(input logic [3:0] id, input logic [31:0] v, input logic mp, input logic [31:0] tgt);
    bus.wb_valid      = 1'b1;
    bus.wb_rob_id     = id;
    bus.wb_value      = v;
    bus.wb_mispredict = mp;
    bus.wb_target     = tgt;
    m_val[id]         = v;
  endtask

  task automatic expect_commit();
    logic [8:0] e;
    #1;
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("commit_rob_id", 32'(bus.commit_rob_id), (e[4:0] == 5'd0) ? 32'd0 : 32'(e[8:5]));
      chk("commit_rd", 32'(bus.commit_rd), 32'(e[4:0]));
      chk("commit_value", bus.commit_value, m_val[e[8:5]]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_val[i] = 32'd0;
    idle_inputs();
    rst = 1'b1;
    model_reset();

    // Reset: outputs held at zero even with stimulus present.
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.issue_rd_in = 5'd3;
    bus.ask_rob_id1 = 4'd1;
    bus.wb_valid    = 1'b1;
    bus.wb_rob_id   = 4'd1;
    bus.wb_value    = 32'h5;
    #1;
    chk("rst_issue_ready", 32'(bus.issue_ready), 32'd0);
    chk("rst_issue_rob_id", 32'(bus.issue_rob_id), 32'd0);
    chk("rst_get_ready1", 32'(bus.get_ready1), 32'd0);
    chk("rst_commit_rob_id", 32'(bus.commit_rob_id), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_flush_pc", bus.flush_pc, 32'd0);
    cycle();
    rst = 1'b0;

    // In-order retirement with out-of-order write-back.
    cycle(); issue(5'd5, 1'b0);
    cycle(); issue(5'd6, 1'b0);
    chk("t1_no_commit", 32'(bus.commit_rob_id), 32'd0);
    cycle(); wb(4'd2, 32'h22, 1'b0, 32'd0); #1;
    chk("t1_head_not_ready", 32'(bus.commit_rob_id), 32'd0);
    cycle(); wb(4'd1, 32'h11, 1'b0, 32'd0); #1;
    chk("t1_no_wb_bypass_commit", 32'(bus.commit_rob_id), 32'd0);
    cycle(); expect_commit();
    cycle(); expect_commit();
    cycle(); #1;
    chk("t1_empty_no_commit", 32'(bus.commit_rob_id), 32'd0);
    chk("t1_empty_commit_value", bus.commit_value, 32'd0);

    // Fill to DEPTH, then commit + issue in the same cycle.
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      cycle(); issue(5'(i), 1'b0);
    end
    cycle();
    bus.issue_valid = 1'b1;
    bus.issue_rd_in = 5'd20;
    #1;
    chk("t2_full_issue_ready", 32'(bus.issue_ready), 32'd0);
    chk("t2_full_issue_rob_id", 32'(bus.issue_rob_id), 32'd0);

    // Query bypass and stored lookup.
    cycle();
    wb(4'd3, 32'hABCD, 1'b0, 32'd0);
    bus.ask_rob_id1 = 4'd3;
    bus.ask_rob_id2 = 4'd0;
    #1;
    chk("t3_bypass_ready", 32'(bus.get_ready1), 32'd1);
    chk("t3_bypass_value", bus.get_value1, 32'hABCD);
    chk("t3_ask0_ready", 32'(bus.get_ready2), 32'd0);
    chk("t3_ask0_value", bus.get_value2, 32'd0);
    cycle();
    bus.ask_rob_id1 = 4'd3;
    bus.ask_rob_id2 = 4'd4;
    #1;
    chk("t3_stored_ready", 32'(bus.get_ready1), 32'd1);
    chk("t3_stored_value", bus.get_value1, 32'hABCD);
    chk("t3_pending_ready", 32'(bus.get_ready2), 32'd0);

    cycle(); wb(4'd1, 32'h1111, 1'b0, 32'd0); #1;
    chk("t2_commit_wait", 32'(bus.commit_rob_id), 32'd0);
    cycle();
    bus.issue_valid = 1'b1;
    bus.issue_rd_in = 5'd7;
    expect_commit();
    chk("t2_full_commit_issue_ready", 32'(bus.issue_ready), 32'd0);
    chk("t2_full_commit_issue_rob_id", 32'(bus.issue_rob_id), 32'd0);
    cycle(); issue(5'd7, 1'b0);
    cycle();
    bus.issue_valid = 1'b1;
    #1;
    chk("t2_full_again", 32'(bus.issue_ready), 32'd0);

    // Mispredicted branch at the head flushes everything.
    do_reset();
    cycle(); issue(5'd8, 1'b1);
    for (int i = 9; i <= 11; i++) begin
      cycle(); issue(5'(i), 1'b0);
    end
    cycle(); wb(4'd1, 32'h44, 1'b1, 32'h1000); #1;
    chk("t4_no_commit_yet", 32'(bus.commit_rob_id), 32'd0);
    cycle();
    bus.issue_valid = 1'b1;
    bus.issue_rd_in = 5'd13;
    wb(4'd2, 32'h99, 1'b0, 32'd0);
    expect_commit();
    chk("t4_hfc_issue_ready", 32'(bus.issue_ready), 32'd0);
    chk("t4_hfc_issue_rob_id", 32'(bus.issue_rob_id), 32'd0);
    chk("t4_hfc_flush_low", 32'(bus.flush), 32'd0);
    cycle();
    model_reset();
    bus.issue_valid = 1'b1;
    bus.issue_rd_in = 5'd13;
    bus.ask_rob_id2 = 4'd2;
    #1;
    chk("t4_flush", 32'(bus.flush), 32'd1);
    chk("t4_flush_pc", bus.flush_pc, 32'h1000);
    chk("t4_flush_issue_ready", 32'(bus.issue_ready), 32'd0);
    chk("t4_flush_commit", 32'(bus.commit_rob_id), 32'd0);
    chk("t4_wb_discarded", 32'(bus.get_ready2), 32'd0);
    cycle(); #1;
    chk("t4_flush_pulse_end", 32'(bus.flush), 32'd0);
    issue(5'd12, 1'b0);

    // rd = 0: no rename, silent retirement that still advances head.
    do_reset();
    cycle(); issue(5'd0, 1'b0);
    cycle(); issue(5'd4, 1'b0);
    cycle(); wb(4'd1, 32'h55, 1'b0, 32'd0); #1;
    chk("t5_commit_wait", 32'(bus.commit_value), 32'd0);
    cycle(); wb(4'd2, 32'h66, 1'b0, 32'd0); expect_commit();
    cycle(); expect_commit();

    // rdy low freezes state; query bypass stays live.
    cycle(); issue(5'd9, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      rdy = 1'b0;
      bus.issue_valid = 1'b1;
      bus.issue_rd_in = 5'd1;
      bus.wb_valid    = 1'b1;
      bus.wb_rob_id   = 4'd3;
      bus.wb_value    = 32'h77;
      bus.ask_rob_id1 = 4'd3;
      #1;
      chk("t6_stall_issue_ready", 32'(bus.issue_ready), 32'd0);
      chk("t6_stall_issue_rob_id", 32'(bus.issue_rob_id), 32'd0);
      chk("t6_stall_bypass", 32'(bus.get_ready1), 32'd1);
    end
    cycle();
    bus.ask_rob_id1 = 4'd3;
    #1;
    chk("t6_wb_lost_while_stalled", 32'(bus.get_ready1), 32'd0);
    chk("t6_no_commit", 32'(bus.commit_rob_id), 32'd0);
    issue(5'd10, 1'b0);
    cycle(); wb(4'd3, 32'h77, 1'b0, 32'd0);
    cycle(); expect_commit();

    // Reset in the middle of traffic.
    cycle();
    rst = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_rd_in = 5'd3;
    bus.wb_valid    = 1'b1;
    bus.wb_rob_id   = 4'd4;
    bus.wb_value    = 32'h88;
    bus.ask_rob_id1 = 4'd4;
    #1;
    chk("t6_rst_issue_ready", 32'(bus.issue_ready), 32'd0);
    chk("t6_rst_issue_rob_id", 32'(bus.issue_rob_id), 32'd0);
    chk("t6_rst_issue_rd", 32'(bus.issue_rd), 32'd0);
    chk("t6_rst_get_ready1", 32'(bus.get_ready1), 32'd0);
    chk("t6_rst_get_value1", bus.get_value1, 32'd0);
    chk("t6_rst_commit_value", bus.commit_value, 32'd0);
    cycle();
    rst = 1'b0;
    model_reset();
    cycle(); issue(5'd11, 1'b0);
    cycle(); #1;
    chk("t6_post_rst_no_commit", 32'(bus.commit_rob_id), 32'd0);
    chk("t6_post_rst_no_flush", 32'(bus.flush), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
